// File: rtl/spi_byte_engine.sv
// Byte-wide SPI mode-0 master: shifts one byte MSB-first at a selectable SCLK rate
// and keeps a running CRC16-CCITT over either the sent or the received bits.
module spi_byte_engine #(
    parameter int DIV_SLOW = 32,
    parameter int DIV_MED  = 8,
    parameter int DIV_FAST = 2
) (
    input  logic        clk,
    input  logic        _reset,
    input  logic        start_write,
    input  logic        start_read,
    input  logic [7:0]  shift_in,
    input  logic [1:0]  speed,
    input  logic        crc_reset,
    input  logic        crc_source,
    input  logic        miso,
    output logic [7:0]  shift_out,
    output logic [15:0] crc_out,
    output logic        mosi,
    output logic        sclk,
    output logic        busy
);

    localparam int DIV_MAX = (DIV_SLOW > DIV_MED)
                           ? ((DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST)
                           : ((DIV_MED > DIV_FAST) ? DIV_MED : DIV_FAST);
    localparam int CW = $clog2(DIV_MAX + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;

    logic [1:0]    state;
    logic [7:0]    tx;
    logic [7:0]    rx;
    logic [2:0]    bit_idx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] half;
    logic          src;

    logic [CW-1:0] half_sel;
    logic [7:0]    load_byte;
    logic          rise;
    logic          crc_bit;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
        return {c[14:0], 1'b0} ^ ((c[15] ^ d) ? 16'h1021 : 16'h0000);
    endfunction

    always_comb begin
        half_sel = CW'(1);
        case (speed)
            2'b00:   half_sel = CW'(DIV_SLOW);
            2'b01:   half_sel = CW'(DIV_MED);
            2'b10:   half_sel = CW'(DIV_FAST);
            default: half_sel = CW'(1);
        endcase
    end

    assign load_byte = start_write ? shift_in : 8'hFF;
    assign rise      = (state == ST_LOW) && (cnt == '0);
    assign crc_bit   = src ? miso : tx[bit_idx];
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state     <= ST_IDLE;
            tx        <= 8'hFF;
            rx        <= 8'hFF;
            bit_idx   <= 3'd7;
            cnt       <= '0;
            half      <= CW'(1);
            src       <= 1'b0;
            sclk      <= 1'b0;
            mosi      <= 1'b1;
            shift_out <= 8'hFF;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_write || start_read) begin
                        tx      <= load_byte;
                        mosi    <= load_byte[7];
                        half    <= half_sel;
                        cnt     <= half_sel - CW'(1);
                        src     <= crc_source;
                        bit_idx <= 3'd7;
                        state   <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (cnt == '0) begin
                        sclk        <= 1'b1;
                        rx[bit_idx] <= miso;
                        cnt         <= half - CW'(1);
                        state       <= ST_HIGH;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_HIGH: begin
                    if (cnt == '0) begin
                        sclk <= 1'b0;
                        if (bit_idx == 3'd0) begin
                            shift_out <= rx;
                            state     <= ST_IDLE;
                        end else begin
                            // next data bit goes out on the falling edge, a full half-period ahead of its rise
                            bit_idx <= bit_idx - 3'd1;
                            mosi    <= tx[bit_idx - 3'd1];
                            cnt     <= half - CW'(1);
                            state   <= ST_LOW;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // clearing wins over a bit landing in the same cycle
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset)
            crc_out <= 16'h0000;
        else if (crc_reset)
            crc_out <= 16'h0000;
        else if (rise)
            crc_out <= crc_step(crc_out, crc_bit);
    end

endmodule

// File: tb/tb_spi_byte_engine.sv
// Bench for spi_byte_engine: a timeline model indexed by cycles-since-start checks every
// output each cycle, plus literal expectations for the documented scenarios.
module tb_spi_byte_engine;

    logic        clk = 1'b0;
    logic        _reset;
    logic        start_write, start_read, crc_reset, crc_source;
    logic [7:0]  shift_in;
    logic [1:0]  speed;
    logic        miso;
    logic [7:0]  shift_out;
    logic [15:0] crc_out;
    logic        mosi, sclk, busy;

    logic        loopback;
    logic        miso_drv;
    int          checks = 0;
    int          failures = 0;

    assign miso = loopback ? mosi : miso_drv;

    always #5 clk = ~clk;

    spi_byte_engine dut (
        .clk(clk), ._reset(_reset), .start_write(start_write), .start_read(start_read),
        .shift_in(shift_in), .speed(speed), .crc_reset(crc_reset), .crc_source(crc_source),
        .miso(miso), .shift_out(shift_out), .crc_out(crc_out), .mosi(mosi), .sclk(sclk),
        .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] crc_model(input logic [15:0] c, input logic d);
        logic [15:0] r;
        r = c << 1;
        if (c[15] != d) r = r ^ 16'h1021;
        return r;
    endfunction

    function automatic int half_of(input logic [1:0] s);
        case (s)
            2'b00:   return 32;
            2'b01:   return 8;
            2'b10:   return 2;
            default: return 1;
        endcase
    endfunction

    // independent observers
    logic [7:0] rise_bits = 8'h00;
    time        last_rise = 0;
    time        sclk_per = 0;
    int         byte_cnt = 0;
    always @(posedge sclk) begin
        rise_bits = {rise_bits[6:0], mosi};
        sclk_per  = $time - last_rise;
        last_rise = $time;
    end
    always @(negedge busy) byte_cnt++;

    // model: position in the byte is k = edges since the start edge
    bit          m_busy = 0, m_sclk = 0, m_mosi = 1, m_src = 0;
    logic [7:0]  m_tx = 8'hFF, m_rx = 8'hFF, m_so = 8'hFF;
    logic [15:0] m_crc = 16'h0;
    int          m_k = 0, m_H = 1;

    always @(negedge clk) begin
        bit   rise;
        bit   fall;
        int   b;
        logic d;
        if (!_reset) begin
            m_busy = 0; m_sclk = 0; m_mosi = 1; m_so = 8'hFF; m_crc = 16'h0;
        end
        check("busy", busy, m_busy);
        check("sclk", sclk, m_sclk);
        check("mosi", mosi, m_mosi);
        check("shift_out", shift_out, m_so);
        check("crc_out", crc_out, m_crc);
        rise = 0;
        d = 1'b0;
        if (_reset) begin
            if (m_busy) begin
                m_k++;
                rise = (m_k % (2 * m_H)) == m_H;
                fall = (m_k % (2 * m_H)) == 0;
                b = 7 - m_k / (2 * m_H);
                if (rise) begin
                    m_sclk  = 1;
                    m_rx[b] = miso;
                    d = m_src ? miso : m_tx[b];
                end
                if (fall) begin
                    m_sclk = 0;
                    if (m_k == 16 * m_H) begin
                        m_busy = 0;
                        m_so   = m_rx;
                    end else begin
                        m_mosi = m_tx[b];
                    end
                end
            end else if (start_write || start_read) begin
                m_busy = 1;
                m_tx   = start_write ? shift_in : 8'hFF;
                m_H    = half_of(speed);
                m_src  = crc_source;
                m_k    = 0;
                m_mosi = m_tx[7];
            end
            if (crc_reset) m_crc = 16'h0;
            else if (rise) m_crc = crc_model(m_crc, d);
        end
    end

    // one byte from strobe to busy low; miso follows pat, changing on sclk falls
    task automatic run_byte(input bit wr, input bit rd, input logic [7:0] d, input logic [1:0] spd,
                            input bit src, input logic [7:0] pat, input int poke_at,
                            input int crst_at, output int cycles);
        int n;
        int idx;
        bit prev;
        shift_in = d; speed = spd; crc_source = src;
        start_write = wr; start_read = rd;
        idx = 7; miso_drv = pat[7]; prev = 0; n = 0;
        do begin
            @(posedge clk); #1;
            start_write = 0; start_read = 0; crc_reset = 0;
            n++;
            if (crst_at > 0 && n == crst_at + 1) check("crc_coincident", crc_out, 32'h0);
            if (prev && !sclk && idx > 0) begin idx--; miso_drv = pat[idx]; end
            prev = sclk;
            if (n == poke_at) begin start_write = 1; start_read = 1; shift_in = ~d; end
            if (n == crst_at) crc_reset = 1;
        end while (busy && n < 4000);
        if (busy) check("byte_timeout", 32'd1, 32'd0);
        cycles = n - 1;
    endtask

    task automatic crc_pulse();
        crc_reset = 1;
        @(posedge clk); #1;
        crc_reset = 0;
    endtask

    initial begin
        int n;
        int bc0;
        _reset = 0; start_write = 0; start_read = 0; crc_reset = 0; crc_source = 0;
        shift_in = 8'h00; speed = 2'b11; loopback = 0; miso_drv = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 1);
        check("rst_shift_out", shift_out, 8'hFF);
        check("rst_crc", crc_out, 16'h0);
        _reset = 1;
        @(posedge clk); #1;

        loopback = 1;
        run_byte(1, 0, 8'hA5, 2'b11, 0, 8'hFF, 0, 0, n);
        check("wr_fast_cycles", n, 16);
        check("wr_fast_rise_bits", rise_bits, 8'hA5);
        check("wr_fast_shift_out", shift_out, 8'hA5);

        loopback = 0;
        run_byte(0, 1, 8'h00, 2'b00, 0, 8'h3C, 0, 0, n);
        check("rd_slow_cycles", n, 512);
        check("rd_slow_sclk_period", 32'(sclk_per), 640);
        check("rd_slow_shift_out", shift_out, 8'h3C);

        crc_pulse();
        run_byte(1, 0, 8'h01, 2'b11, 0, 8'hFF, 0, 0, n);
        check("crc_tx_01", crc_out, 16'h1021);

        crc_pulse();
        repeat (512) run_byte(1, 0, 8'hFF, 2'b11, 0, 8'hFF, 0, 0, n);
        check("crc_tx_512ff", crc_out, 16'h7FA1);

        crc_pulse();
        repeat (512) run_byte(0, 1, 8'h00, 2'b11, 1, 8'hFF, 0, 0, n);
        check("crc_rx_512ff", crc_out, 16'h7FA1);

        crc_pulse();
        repeat (512) run_byte(0, 1, 8'h00, 2'b11, 0, 8'h00, 0, 0, n);
        check("crc_txsrc_reads", crc_out, 16'h7FA1);
        check("crc_txsrc_shift_out", shift_out, 8'h00);

        loopback = 1;
        run_byte(1, 1, 8'h5A, 2'b11, 0, 8'hFF, 0, 0, n);
        check("both_strobes", shift_out, 8'h5A);

        bc0 = byte_cnt;
        run_byte(1, 0, 8'h33, 2'b10, 0, 8'hFF, 10, 0, n);
        check("busy_strobe_cycles", n, 32);
        check("busy_strobe_count", byte_cnt - bc0, 1);
        check("busy_strobe_shift_out", shift_out, 8'h33);

        run_byte(1, 0, 8'hC3, 2'b11, 0, 8'hFF, 0, 1, n);

        shift_in = 8'hC3; speed = 2'b01; start_write = 1;
        @(posedge clk); #1;
        start_write = 0;
        repeat (57) @(posedge clk);
        #1;
        _reset = 0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_sclk", sclk, 0);
        check("midrst_mosi", mosi, 1);
        check("midrst_shift_out", shift_out, 8'hFF);
        check("midrst_crc", crc_out, 16'h0);
        repeat (3) @(posedge clk);
        #1;
        _reset = 1;
        run_byte(1, 0, 8'h96, 2'b01, 0, 8'hFF, 0, 0, n);
        check("postrst_cycles", n, 128);
        check("postrst_shift_out", shift_out, 8'h96);

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
